// File: rtl/team_06_reverb_pkg.sv
// Shared types, default widths and the output saturation helper for the multitap reverb.
package team_06_reverb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MIX   = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_ADDR_W   = 13;
  localparam int unsigned DEF_NUM_TAPS = 2;
  localparam int unsigned DEF_SHIFT_W  = 3;
  localparam int unsigned DEF_TIMEOUT  = 16;

  // Floor-halve the accumulator and clamp to the largest data_w-bit sample.
  function automatic logic [31:0] sat_half(input logic [31:0] acc, input int unsigned data_w);
    logic [31:0] half;
    logic [31:0] lim;
    half = acc >> 1;
    lim  = (32'd1 << data_w) - 32'd1;
    return (half > lim) ? lim : half;
  endfunction

endpackage

// File: rtl/team_06_reverb_multitap_tap_scaler.sv
// Combinational per-tap attenuation: the fetched past sample right-shifted by its tap shift.
module team_06_tap_scaler
  import team_06_reverb_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned SHIFT_W = DEF_SHIFT_W
) (
  input  logic [DATA_W-1:0]  past_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [DATA_W-1:0]  scaled_o
);

  assign scaled_o = past_i >> shift_i;

endmodule

// File: rtl/team_06_reverb_multitap.sv
// Multitap reverb mixer: dry sample plus NUM_TAPS attenuated memory taps, halved and saturated.
// Optional read timeout per tap enabled by defining TEAM_06_REVERB_TIMEOUT_EN.
module team_06_reverb_multitap
  import team_06_reverb_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
  parameter int unsigned SHIFT_W  = DEF_SHIFT_W
`ifdef TEAM_06_REVERB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reverb_enable,
  input  logic                         sample_valid,
  input  logic [DATA_W-1:0]            audio_in,
  input  logic [NUM_TAPS*ADDR_W-1:0]   tap_delay,
  input  logic [NUM_TAPS*SHIFT_W-1:0]  tap_shift,
  input  logic [DATA_W-1:0]            past_output,
  input  logic                         past_valid,
  output logic                         r_search,
  output logic [ADDR_W-1:0]            r_offset,
  output logic [DATA_W-1:0]            reverb_out,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            save_audio,
  output logic                         save_valid,
  output logic                         busy,
  output logic                         overrun
`ifdef TEAM_06_REVERB_TIMEOUT_EN
  , output logic                       timeout_err
`endif
);

  localparam int unsigned ACC_W = DATA_W + $clog2(NUM_TAPS + 1);
  localparam int unsigned IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               r_search_q;
  logic [ADDR_W-1:0]  r_offset_q, r_offset_d;
  logic [DATA_W-1:0]  reverb_q, mix_d;
  logic [DATA_W-1:0]  save_q;
  logic               out_valid_q, save_valid_q, overrun_q;
  logic [SHIFT_W-1:0] shift_sel;
  logic [DATA_W-1:0]  scaled;
  logic               tap_done;

`ifdef TEAM_06_REVERB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;
  logic             timeout_err_q;
  assign tmo_hit     = !past_valid && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign timeout_err = timeout_err_q;
`endif

  team_06_tap_scaler #(
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W)
  ) u_scaler (
    .past_i   (past_output),
    .shift_i  (shift_sel),
    .scaled_o (scaled)
  );

  always_comb begin
    shift_sel  = tap_shift[idx_q*SHIFT_W +: SHIFT_W];
    idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    r_offset_d = tap_delay[idx_d*ADDR_W +: ADDR_W];
    mix_d      = DATA_W'(sat_half(32'(acc_q), DATA_W));
`ifdef TEAM_06_REVERB_TIMEOUT_EN
    // A timed-out tap advances the FSM but adds nothing to the mix.
    tap_done = past_valid | tmo_hit;
    acc_d    = acc_q + (past_valid ? ACC_W'(scaled) : '0);
`else
    tap_done = past_valid;
    acc_d    = acc_q + ACC_W'(scaled);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      idx_q        <= '0;
      r_search_q   <= 1'b0;
      r_offset_q   <= '0;
      reverb_q     <= '0;
      save_q       <= '0;
      out_valid_q  <= 1'b0;
      save_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef TEAM_06_REVERB_TIMEOUT_EN
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      if (sample_valid && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            if (reverb_enable) begin
              acc_q      <= ACC_W'(audio_in);
              idx_q      <= '0;
              r_search_q <= 1'b1;
              r_offset_q <= tap_delay[ADDR_W-1:0];
`ifdef TEAM_06_REVERB_TIMEOUT_EN
              tmo_q      <= '0;
`endif
              state_q    <= FETCH;
            end else begin
              reverb_q     <= audio_in;
              save_q       <= audio_in;
              out_valid_q  <= 1'b1;
              save_valid_q <= 1'b1;
              state_q      <= OUT;
            end
          end
        end
        FETCH: begin
          if (tap_done) begin
            acc_q <= acc_d;
`ifdef TEAM_06_REVERB_TIMEOUT_EN
            tmo_q <= '0;
            if (tmo_hit) timeout_err_q <= 1'b1;
`endif
            if (idx_q == LAST_IDX) begin
              r_search_q <= 1'b0;
              state_q    <= MIX;
            end else begin
              idx_q      <= idx_d;
              r_offset_q <= r_offset_d;
            end
          end
`ifdef TEAM_06_REVERB_TIMEOUT_EN
          else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        MIX: begin
          reverb_q     <= mix_d;
          save_q       <= mix_d;
          out_valid_q  <= 1'b1;
          save_valid_q <= 1'b1;
          state_q      <= OUT;
        end
        OUT: begin
          out_valid_q  <= 1'b0;
          save_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r_search   = r_search_q;
  assign r_offset   = r_offset_q;
  assign reverb_out = reverb_q;
  assign save_audio = save_q;
  assign out_valid  = out_valid_q;
  assign save_valid = save_valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_team_06_reverb_multitap.sv
// Directed bench: a 1-tap and a 2-tap instance share stimulus; sel picks the one under test.
module tb_team_06_reverb_multitap;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        reverb_enable, sample_valid, past_valid;
  logic [7:0]  audio_in, past_output;
  logic [12:0] tap_delay1;
  logic [2:0]  tap_shift1;
  logic [25:0] tap_delay2;
  logic [5:0]  tap_shift2;

  logic        rs1, ov1, sv1o, busy1, ovr1;
  logic [12:0] off1;
  logic [7:0]  rout1, save1;
  logic        rs2, ov2, sv2o, busy2, ovr2;
  logic [12:0] off2;
  logic [7:0]  rout2, save2;
`ifdef TEAM_06_REVERB_TIMEOUT_EN
  logic        terr1, terr2;
`endif

  logic        v_r_search, v_out_valid, v_save_valid, v_busy, v_overrun;
  logic [12:0] v_r_offset;
  logic [7:0]  v_reverb_out, v_save_audio;

  int cyc = 0;
  int t0 = 0;
  int n_total = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  team_06_reverb_multitap #(
    .DATA_W   (8),
    .ADDR_W   (13),
    .NUM_TAPS (1),
    .SHIFT_W  (3)
`ifdef TEAM_06_REVERB_TIMEOUT_EN
    , .TIMEOUT (16)
`endif
  ) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .reverb_enable (reverb_enable),
    .sample_valid  (sample_valid & ~sel),
    .audio_in      (audio_in),
    .tap_delay     (tap_delay1),
    .tap_shift     (tap_shift1),
    .past_output   (past_output),
    .past_valid    (past_valid),
    .r_search      (rs1),
    .r_offset      (off1),
    .reverb_out    (rout1),
    .out_valid     (ov1),
    .save_audio    (save1),
    .save_valid    (sv1o),
    .busy          (busy1),
    .overrun       (ovr1)
`ifdef TEAM_06_REVERB_TIMEOUT_EN
    , .timeout_err (terr1)
`endif
  );

  team_06_reverb_multitap #(
    .DATA_W   (8),
    .ADDR_W   (13),
    .NUM_TAPS (2),
    .SHIFT_W  (3)
`ifdef TEAM_06_REVERB_TIMEOUT_EN
    , .TIMEOUT (16)
`endif
  ) u_dut2 (
    .clk           (clk),
    .rst           (rst),
    .reverb_enable (reverb_enable),
    .sample_valid  (sample_valid & sel),
    .audio_in      (audio_in),
    .tap_delay     (tap_delay2),
    .tap_shift     (tap_shift2),
    .past_output   (past_output),
    .past_valid    (past_valid),
    .r_search      (rs2),
    .r_offset      (off2),
    .reverb_out    (rout2),
    .out_valid     (ov2),
    .save_audio    (save2),
    .save_valid    (sv2o),
    .busy          (busy2),
    .overrun       (ovr2)
`ifdef TEAM_06_REVERB_TIMEOUT_EN
    , .timeout_err (terr2)
`endif
  );

  assign v_r_search   = sel ? rs2   : rs1;
  assign v_r_offset   = sel ? off2  : off1;
  assign v_reverb_out = sel ? rout2 : rout1;
  assign v_out_valid  = sel ? ov2   : ov1;
  assign v_save_audio = sel ? save2 : save1;
  assign v_save_valid = sel ? sv2o  : sv1o;
  assign v_busy       = sel ? busy2 : busy1;
  assign v_overrun    = sel ? ovr2  : ovr1;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] a, input logic en);
    @(negedge clk);
    audio_in      = a;
    reverb_enable = en;
    sample_valid  = 1'b1;
    t0            = cyc;
    @(negedge clk);
    sample_valid  = 1'b0;
  endtask

  // Memory responder for one tap: stall for 'waits' cycles, then return data.
  task automatic serve(input string tag, input int off, input logic [7:0] d, input int waits);
    bit held = 1'b1;
    for (int w = 0; w < waits; w++) begin
      if (!v_r_search || v_r_offset != 13'(off)) held = 1'b0;
      @(negedge clk);
    end
    if (waits > 0) check({tag, "_held"}, int'(held), 1);
    check({tag, "_search"}, int'(v_r_search), 1);
    check({tag, "_offset"}, int'(v_r_offset), off);
    past_output = d;
    past_valid  = 1'b1;
    @(negedge clk);
    past_valid  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int exp_val, input int exp_lat, input int exp_search);
    bit seen = 1'b0;
    bit searched = 1'b0;
    int lat = -1;
    for (int k = 0; k < 64 && !seen; k++) begin
      if (v_r_search) searched = 1'b1;
      if (v_out_valid) begin
        seen = 1'b1;
        lat  = cyc - t0;
        check({tag, "_out"}, int'(v_reverb_out), exp_val);
        check({tag, "_save"}, int'(v_save_audio), exp_val);
        check({tag, "_save_valid"}, int'(v_save_valid), 1);
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_seen"}, int'(seen), 1);
    if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
    if (exp_search >= 0) check({tag, "_search"}, int'(searched), exp_search);
    if (seen) begin
      @(negedge clk);
      check({tag, "_pulse"}, int'(v_out_valid), 0);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0;
    reverb_enable = 1'b0; sample_valid = 1'b0; past_valid = 1'b0;
    audio_in = '0; past_output = '0;
    tap_delay1 = 13'd500; tap_shift1 = 3'd0;
    tap_delay2 = {13'd2000, 13'd100}; tap_shift2 = {3'd1, 3'd0};
    repeat (2) @(negedge clk);
    check("rst_out", int'(v_reverb_out), 0);
    check("rst_valid", int'(v_out_valid), 0);
    check("rst_search", int'(v_r_search), 0);
    check("rst_busy", int'(v_busy), 0);
    check("rst_overrun", int'(v_overrun), 0);
    rst = 1'b0;

    // Single tap, no attenuation: floor((audio + past) / 2).
    send(8'd68, 1'b1);  serve("t1a", 500, 8'd50, 0);  expect_out("t1a", 59, 3, -1);
    send(8'd255, 1'b1); serve("t1b", 500, 8'd255, 0); expect_out("t1b", 255, 3, -1);
    send(8'd254, 1'b1); serve("t1c", 500, 8'd255, 0); expect_out("t1c", 254, 3, -1);
    send(8'd12, 1'b1);  serve("t1d", 500, 8'd255, 0); expect_out("t1d", 133, 3, -1);
    send(8'd75, 1'b0);  expect_out("byp", 75, 1, 0);

    // Two taps, shifts {0,1}, delays {100,2000}.
    sel = 1'b1;
    send(8'd200, 1'b1); serve("s0a", 100, 8'd255, 0); serve("s1a", 2000, 8'd255, 0);
    expect_out("sat", 255, 4, -1);
    send(8'd40, 1'b1);  serve("s0b", 100, 8'd20, 0);  serve("s1b", 2000, 8'd60, 0);
    expect_out("mix", 45, 4, -1);
    send(8'd40, 1'b1);  serve("s0c", 100, 8'd20, 3);  serve("s1c", 2000, 8'd60, 3);
    expect_out("stall", 45, 10, -1);

    // Overrun: a second sample during FETCH is dropped.
    check("ovr_pre", int'(v_overrun), 0);
    send(8'd40, 1'b1);
    audio_in = 8'd9; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("ovr_set", int'(v_overrun), 1);
    serve("s0d", 100, 8'd20, 0); serve("s1d", 2000, 8'd60, 0);
    expect_out("ovr", 45, -1, -1);
    check("ovr_idle", int'(v_busy), 0);

    // Asynchronous reset in the middle of FETCH.
    send(8'd40, 1'b1);
    check("mid_search", int'(v_r_search), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_search", int'(v_r_search), 0);
    check("mid_rst_offset", int'(v_r_offset), 0);
    check("mid_rst_busy", int'(v_busy), 0);
    check("mid_rst_out", int'(v_reverb_out), 0);
    check("mid_rst_save", int'(v_save_audio), 0);
    check("mid_rst_overrun", int'(v_overrun), 0);
    check("mid_rst_valid", int'(v_out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'd40, 1'b1);  serve("s0e", 100, 8'd20, 0);  serve("s1e", 2000, 8'd60, 0);
    expect_out("post_rst", 45, 4, -1);

`ifdef TEAM_06_REVERB_TIMEOUT_EN
    sel = 1'b0;
    check("tmo_pre", int'(terr1), 0);
    send(8'd100, 1'b1);
    expect_out("tmo", 50, 18, -1);
    check("tmo_err", int'(terr1), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/team_06_reverb_multitap.md
Name: team_06_reverb_multitap

Overview:
- Parametrised successor to the single-tap reverb.
- Mixes each incoming audio sample with NUM_TAPS delayed samples fetched one at a time from the shared sample memory via an r_search/r_offset request–valid handshake.
- Each tap is attenuated by a per-tap right shift; the sum is halved and saturated.
- Sits between the audio input sampler and the output/PWM stage; save_audio feeds the memory writer so past outputs produce recirculating reverb.

Parameters:
- DATA_W, 8, unsigned audio sample width.
- ADDR_W, 13, width of each tap offset (r_offset).
- NUM_TAPS, 2, number of delayed taps fetched per sample (>=1).
- SHIFT_W, 3, width of each per-tap attenuation shift.
- TIMEOUT, 16, cycles to wait for past_valid (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- reverb_enable  in  1  1 = reverb, 0 = bypass; sampled on sample acceptance.
- sample_valid  in  1  one-cycle strobe; audio_in is valid.
- audio_in  in  DATA_W  dry input sample.
- tap_delay  in  NUM_TAPS*ADDR_W  packed offsets; tap i at [i*ADDR_W +: ADDR_W].
- tap_shift  in  NUM_TAPS*SHIFT_W  packed per-tap attenuation shifts.
- past_output  in  DATA_W  memory read data.
- past_valid  in  1  past_output is valid for the current r_offset.
- r_search  out  1  memory read request.
- r_offset  out  ADDR_W  requested offset.
- reverb_out  out  DATA_W  mixed output, held between samples.
- out_valid  out  1  one-cycle strobe; reverb_out updated.
- save_audio  out  DATA_W  sample to write back to memory (equals reverb_out).
- save_valid  out  1  write strobe, coincident with out_valid.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky; a sample_valid arrived while busy.

Behaviour:
- Reset (asynchronous) clears all of the following to 0 and places the FSM in IDLE, regardless of state: reverb_out, save_audio, out_valid, save_valid, r_search, r_offset, overrun, tap index, accumulator.
- FSM states: IDLE, FETCH, MIX, OUT.
- IDLE:
  - On sample_valid, latch audio_in and reverb_enable.
  - If enabled, clear the accumulator to audio_in, set tap index to 0, go to FETCH.
  - Otherwise go to OUT with reverb_out = audio_in (bypass, latency 1).
- FETCH:
  - r_search = 1 and r_offset = tap_delay[idx], held stable until past_valid.
  - past_valid may arrive in the first FETCH cycle.
  - On past_valid, add (past_output >> tap_shift[idx]) to the accumulator.
  - If idx == NUM_TAPS-1, go to MIX; otherwise increment idx and stay in FETCH (r_search stays high, offset changes).
  - past_valid while r_search = 0 is ignored.
- MIX: reverb_out = min(2^DATA_W - 1, acc >> 1), floor division; go to OUT. r_search = 0.
- OUT: out_valid = save_valid = 1 for exactly one cycle; save_audio = reverb_out; go to IDLE.
- Accumulator width: DATA_W + clog2(NUM_TAPS+1). It never overflows.
- Latency with zero-wait memory: out_valid asserts NUM_TAPS+2 cycles after the sample_valid cycle. Each memory wait cycle adds 1.
- sample_valid while busy: the sample is dropped, overrun is set, and the operation in flight is unaffected. overrun clears only on reset.
- Compatibility: NUM_TAPS = 1 with shift 0 reproduces the previous block, out = floor((audio + past)/2).
- tap_delay and tap_shift are read live in FETCH; software changes them only while idle.

Optional Feature:
- Macro: TEAM_06_REVERB_TIMEOUT_EN.
- Defined: a counter runs in FETCH. If past_valid is absent for TIMEOUT consecutive cycles on a tap, that tap contributes 0, the FSM advances exactly as if past_valid had arrived, and an extra output timeout_err (1 bit, sticky, reset 0) is set.
- Undefined: FETCH waits indefinitely, and the timeout_err port and counter are absent.

Decomposition:
- Package team_06_reverb_pkg holds:
  - FSM state enum (IDLE/FETCH/MIX/OUT).
  - Default width localparams.
  - A saturate-and-halve function.
- Sub-module team_06_tap_scaler (combinational: past_output, shift -> scaled tap). It is instantiated once and muxed by tap index.

Test Plan:
- NUM_TAPS=1, shift 0: audio 68, past 50 -> 59. 255/255 -> 255. 254/255 -> 254. 12/255 -> 133. out_valid 3 cycles after sample_valid.
- NUM_TAPS=2, shifts {0,1}, delays {100,2000}:
  - r_offset 100 then 2000 while r_search is high.
  - audio 200, taps 255, 255: 200+255+127 = 582 -> saturates to 255.
  - audio 40, taps 20, 60: 40+20+30 = 90 -> 45.
  - save_audio matches reverb_out; save_valid coincides with out_valid.
- Memory stalls: past_valid delayed 3 cycles per tap -> r_offset held stable, latency +6, same result.
- Bypass: reverb_enable=0, audio 75 -> reverb_out 75 one cycle later, r_search never asserted.
- Second sample_valid during FETCH -> overrun=1, first result unaffected. rst pulsed mid-FETCH -> all outputs 0, IDLE, r_search drops immediately.
- With TEAM_06_REVERB_TIMEOUT_EN and TIMEOUT=16: no past_valid -> after 16 cycles tap treated as 0, timeout_err=1, audio 100 -> 50.
